// File: rtl/frv_dmem_responder_if.sv
// Data-memory request/response bundle between the LSU (master) and a
// responder target (slave).
interface frv_dmem_responder_if;
  logic        dmem_req;
  logic        dmem_wen;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_recv;
  logic        dmem_ack;
  logic        dmem_error;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    input  dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_wen, dmem_strb, dmem_wdata, dmem_addr, dmem_ack,
    output dmem_gnt, dmem_recv, dmem_error, dmem_rdata
  );
endinterface

// File: rtl/frv_dmem_responder.sv
// Tightly-coupled data RAM target: req/gnt accept, byte-strobed RAM, in-order
// recv/ack response queue. Define FRV_DMEM_RSP_STALL_EN for LFSR-driven stalls.
module frv_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  frv_dmem_responder_if.slave  dmem
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W       = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W       = $clog2(OUTSTANDING + 1);
  localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);

  // Queue bookkeeping
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             rst_hold_reg;
  logic             fill_pend_reg;
  logic [PTR_W-1:0] fill_slot_reg;

  // Queue payload: error flag, "carries RAM data" flag, captured read data
  logic             q_err_reg  [OUTSTANDING];
  logic             q_rd_reg   [OUTSTANDING];
  logic [31:0]      q_data_reg [OUTSTANDING];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_rdata;
  logic             ram_wr;
  logic             ram_rd;

  logic             gnt_base;
  logic             gnt_mask;
  logic             recv_mask;
  logic             gnt;
  logic             recv;
  logic             accept;
  logic             pop;
  logic [31:0]      head_data;

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range too
  assign offset   = dmem.dmem_addr - BASE_ADDR;
  assign in_range = (offset < RANGE_BYTES);
  assign ram_idx  = offset[IDX_W+1:2];

`ifdef FRV_DMEM_RSP_STALL_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  assign gnt_mask  = (lfsr_reg[1:0] == 2'b00);
  assign recv_mask = (lfsr_reg[3:2] == 2'b00);
`else
  assign gnt_mask  = 1'b0;
  assign recv_mask = 1'b0;
`endif

  // Grant depends only on registered state so ack/req never reach gnt
  assign gnt_base = !g_reset && !rst_hold_reg && (count_reg < CNT_MAX);
  assign gnt      = gnt_base && !gnt_mask;
  assign accept   = dmem.dmem_req && gnt;
  assign recv     = (count_reg != '0) && !g_reset && !recv_mask;
  assign pop      = recv && dmem.dmem_ack;

  assign ram_wr   = accept &&  dmem.dmem_wen && in_range;
  assign ram_rd   = accept && !dmem.dmem_wen && in_range;

  // One byte-wide RAM per lane; registered read lands one cycle after accept
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge g_clk) begin
        if (ram_wr && dmem.dmem_strb[gi]) begin
          mem[ram_idx] <= dmem.dmem_wdata[8*gi +: 8];
        end
        if (ram_rd) begin
          rd_byte_reg <= mem[ram_idx];
        end
      end

      assign ram_rdata[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    unique case ({accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (accept) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end
  end

  // rst_hold keeps grant low for the first cycle after reset releases
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rst_hold_reg  <= 1'b1;
      fill_pend_reg <= 1'b0;
      fill_slot_reg <= '0;
    end else begin
      count_reg     <= count_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      rst_hold_reg  <= 1'b0;
      fill_pend_reg <= ram_rd;
      fill_slot_reg <= wr_ptr_reg;
    end
  end

  // Payload needs no reset; count gates every slot's visibility
  always_ff @(posedge g_clk) begin
    if (accept) begin
      q_err_reg[wr_ptr_reg] <= !in_range;
      q_rd_reg[wr_ptr_reg]  <= !dmem.dmem_wen && in_range;
    end
    if (fill_pend_reg) begin
      q_data_reg[fill_slot_reg] <= ram_rdata;
    end
  end

  // Bypass the RAM output while its data is still on the way into the slot
  assign head_data = (fill_pend_reg && (fill_slot_reg == rd_ptr_reg)) ? ram_rdata
                                                                       : q_data_reg[rd_ptr_reg];

  assign dmem.dmem_gnt   = gnt;
  assign dmem.dmem_recv  = recv;
  assign dmem.dmem_error = recv && q_err_reg[rd_ptr_reg];
  assign dmem.dmem_rdata = (recv && q_rd_reg[rd_ptr_reg]) ? head_data : 32'h0;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Scoreboard bench for frv_dmem_responder (default build, BASE=0, 1024 words,
// two outstanding responses).
module tb_frv_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] RANGE = 32'h0000_1000;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic g_clk;
  logic g_reset;

  frv_dmem_responder_if bus ();

  frv_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .OUTSTANDING (2)
  ) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .dmem    (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  rsp_t        sb [$];
  logic [31:0] model_mem [DEPTH];

  logic        obs_gnt, obs_recv, obs_err;
  logic [31:0] obs_rdata;
  logic        last_acc, last_pop, exp_valid;
  rsp_t        exp_rsp;

  int errors = 0;
  int checks = 0;

  // Drive one cycle from a negedge, sample outputs, update model/scoreboard,
  // then advance to the next negedge.
  task automatic step(input logic req, input logic wen, input logic [31:0] addr,
                      input logic [3:0] strb, input logic [31:0] wdata, input logic ack);
    rsp_t       r;
    logic [9:0] idx;
    bus.dmem_req   = req;
    bus.dmem_wen   = wen;
    bus.dmem_addr  = addr;
    bus.dmem_strb  = strb;
    bus.dmem_wdata = wdata;
    bus.dmem_ack   = ack;
    #1;
    obs_gnt   = bus.dmem_gnt;
    obs_recv  = bus.dmem_recv;
    obs_err   = bus.dmem_error;
    obs_rdata = bus.dmem_rdata;
    last_acc  = req && obs_gnt;
    last_pop  = obs_recv && ack;
    exp_valid = 1'b0;
    exp_rsp   = '0;
    if (last_pop) begin
      if (sb.size() > 0) begin
        exp_rsp   = sb.pop_front();
        exp_valid = 1'b1;
      end
      $display("rsp  err=%0b rdata=%08h", obs_err, obs_rdata);
    end
    if (last_acc) begin
      idx = addr[11:2];
      if (addr < RANGE) begin
        if (wen) begin
          for (int l = 0; l < 4; l++) begin
            if (strb[l]) model_mem[idx][8*l +: 8] = wdata[8*l +: 8];
          end
          r.err = 1'b0; r.rdata = 32'h0;
        end else begin
          r.err = 1'b0; r.rdata = model_mem[idx];
        end
      end else begin
        r.err = 1'b1; r.rdata = 32'h0;
      end
      sb.push_back(r);
      $display("req  %s addr=%08h strb=%b wdata=%08h", wen ? "wr" : "rd", addr, strb, wdata);
    end
    @(negedge g_clk);
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      checks++;
      if ({obs_gnt, obs_recv, obs_err, obs_rdata} !== 35'h0) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%0b recv=%0b err=%0b rdata=%08h, want all 0",
                 obs_gnt, obs_recv, obs_err, obs_rdata);
      end
    end
    g_reset = 1'b0;
    step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++;
    if ({obs_gnt, obs_recv} !== 2'b00) begin
      errors++;
      $display("FAIL reset_after: got gnt=%0b recv=%0b, want 0 0", obs_gnt, obs_recv);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++;
    if (obs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_gnt_return: got gnt=%0b, want 1", obs_gnt);
    end
  endtask

  task automatic test_write_word();
    step(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({obs_gnt, obs_recv} !== 2'b10) begin
      errors++;
      $display("FAIL write_word_gnt: got gnt=%0b recv=%0b, want 1 0", obs_gnt, obs_recv);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++;
    if (!last_pop || !exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}
        || {obs_err, obs_rdata} !== 33'h0) begin
      errors++;
      $display("FAIL write_word_rsp: got recv=%0b err=%0b rdata=%08h, want recv=1 err=0 rdata=00000000",
               obs_recv, obs_err, obs_rdata);
    end
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++;
    if (obs_recv !== 1'b0) begin
      errors++;
      $display("FAIL write_word_popped: got recv=%0b, want 0", obs_recv);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] t_addr [6] = '{32'h20, 32'h20, 32'h20, 32'h0, 32'h1000, 32'h0};
    logic        t_wen  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  t_strb [6] = '{4'hF, 4'h5, 4'h0, 4'hF, 4'h0, 4'hF};
    logic [31:0] t_data [6] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'h55AA55AA, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(1'b1, t_wen[i], t_addr[i], t_strb[i], t_data[i], 1'b1);
      else if (i == 6) step(1'b1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1);
      else step(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      checks++;
      if (obs_gnt !== 1'b1) begin
        errors++;
        $display("FAIL strobe_gnt[%0d]: got gnt=%0b, want 1", i, obs_gnt);
      end
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL strobe_rsp[%0d]: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   i, obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL strobe_drain: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || model_mem[8] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_timeout: pending=%0d word8=%08h, want 0 and 11bb33dd",
               sb.size(), model_mem[8]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] c_addr [5] = '{32'h10, 32'h20, 32'h0, 32'h0, 32'h0};
    logic        c_ack  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        c_gnt  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] held;
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, c_addr[i], 4'h0, 32'h0, c_ack[i]);
      checks++;
      if (obs_gnt !== c_gnt[i]) begin
        errors++;
        $display("FAIL bp_gnt[%0d]: got gnt=%0b, want %0b", i, obs_gnt, c_gnt[i]);
      end
      if (i == 1) held = obs_rdata;
      if (i >= 1 && i <= 3) begin
        checks++;
        if (obs_recv !== 1'b1 || obs_rdata !== held || obs_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got recv=%0b rdata=%08h, want recv=1 rdata=deadbeef",
                   i, obs_recv, obs_rdata);
        end
      end
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL bp_rsp[%0d]: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   i, obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL bp_order: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: %0d responses pending, want 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        exp_recv;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      step(1'b1, (i % 2) == 0, 32'h40 + 32'(4 * (i / 2)), 4'(1 + (i % 15)), d, 1'b1);
      exp_recv = (i > 0);
      checks++;
      if (obs_gnt !== 1'b1 || obs_recv !== exp_recv) begin
        errors++;
        $display("FAIL stream_flow[%0d]: got gnt=%0b recv=%0b, want gnt=1 recv=%0b",
                 i, obs_gnt, obs_recv, exp_recv);
      end
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL stream_rsp[%0d]: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   i, obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL stream_drain: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: %0d responses pending, want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    g_reset = 1'b1;
    sb.delete();
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    checks++;
    if ({obs_gnt, obs_recv, obs_err, obs_rdata} !== 35'h0) begin
      errors++;
      $display("FAIL midrst_during: got gnt=%0b recv=%0b err=%0b rdata=%08h, want all 0",
               obs_gnt, obs_recv, obs_err, obs_rdata);
    end
    g_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      checks++;
      if (obs_recv !== 1'b0 || (i == 0 && obs_gnt !== 1'b0)) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: got recv=%0b gnt=%0b, want recv=0%s",
                 i, obs_recv, obs_gnt, (i == 0) ? " gnt=0" : "");
      end
    end
    step(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1);
    checks++;
    if (!last_pop || !exp_valid || obs_rdata !== exp_rsp.rdata || obs_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midrst_ram: got recv=%0b rdata=%08h, want recv=1 rdata=deadbeef",
               obs_recv, obs_rdata);
    end
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      if (last_pop) begin
        checks++;
        if (!exp_valid || {obs_err, obs_rdata} !== {exp_rsp.err, exp_rsp.rdata}) begin
          errors++;
          $display("FAIL midrst_drain: got err=%0b rdata=%08h, want err=%0b rdata=%08h",
                   obs_err, obs_rdata, exp_rsp.err, exp_rsp.rdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midrst_timeout: %0d responses pending, want 0", sb.size());
    end
  endtask

  initial begin
    g_reset        = 1'b1;
    bus.dmem_req   = 1'b0;
    bus.dmem_wen   = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_strb  = 4'h0;
    bus.dmem_wdata = 32'h0;
    bus.dmem_ack   = 1'b0;
    @(negedge g_clk);
    test_reset();
    test_write_word();
    test_strobes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frv_dmem_responder.md
Name: frv_dmem_responder

Overview:
- Data-memory responder: the target end of the core's dmem request/response interface.
- Accepts requests from the memory stage's LSU (req/gnt handshake) and performs word-addressed reads and byte-strobed writes into an internal RAM.
- Returns in-order responses (recv/ack handshake) through a small response queue.
- Used as the tightly-coupled data RAM in simulation and FPGA builds, and as a protocol-checking target.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two, 16 to 65536.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- OUTSTANDING, 2, response queue depth (max accepted-but-unacknowledged requests); 1 to 4.

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  synchronous active-high reset
- dmem_req  input  1  request valid
- dmem_wen  input  1  1 = write, 0 = read
- dmem_strb  input  4  write byte strobes; bit i enables byte lane i
- dmem_wdata  input  32  write data
- dmem_addr  input  32  byte address; bits [1:0] ignored
- dmem_gnt  output  1  request accepted this cycle when dmem_req && dmem_gnt
- dmem_recv  output  1  response valid
- dmem_ack  input  1  core accepts response when dmem_recv && dmem_ack
- dmem_error  output  1  response carries a bus error
- dmem_rdata  output  32  response read data

Behaviour:
- Reset:
  - Synchronous, active-high, on g_clk; reset is fixed as one clock, synchronous, active-high.
  - While g_reset=1, and in the cycle after it: dmem_gnt=0, dmem_recv=0, dmem_error=0, dmem_rdata=0.
  - Queue and count are cleared.
  - RAM contents are not reset.
  - Reset asserted mid-transaction discards all pending responses. No response is ever delivered for a request accepted before reset.
- Accept and range check:
  - Accept = dmem_req && dmem_gnt.
  - In range: BASE_ADDR <= dmem_addr < BASE_ADDR + 4*DEPTH_WORDS. RAM index = (dmem_addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Grant:
  - dmem_gnt = !g_reset && (count < OUTSTANDING), using registered count only.
  - No combinational path from dmem_ack or dmem_req to dmem_gnt.
  - A full queue therefore stalls grant for one cycle even when ack frees a slot that cycle.
- Read accept (in range):
  - Queues {error=0, rdata=RAM[index]}.
  - rdata reflects all writes accepted in earlier cycles.
- Write accept (in range):
  - For each i with dmem_strb[i]=1, RAM[index][8i+7:8i] <= dmem_wdata[8i+7:8i]; other lanes are unchanged.
  - Queues {error=0, rdata=0}. strb=0000 is legal: no RAM change, normal response.
- Out-of-range accept: no RAM access; queues {error=1, rdata=0}.
- Response queue:
  - FIFO of depth OUTSTANDING with in-order delivery.
  - An accept at edge N makes the response visible from cycle N+1; minimum latency is 1 cycle.
  - dmem_recv = queue non-empty. dmem_error and dmem_rdata show the head entry and are held stable while dmem_recv && !dmem_ack.
  - Pop on dmem_recv && dmem_ack.
- Count:
  - +1 on accept only; -1 on pop only.
  - Accept and pop in the same cycle leave count unchanged.
  - Push and pop on a one-entry queue hand the new entry to the head next cycle.
  - count never exceeds OUTSTANDING; the queue pointers wrap modulo OUTSTANDING.
- Request-side rules:
  - The responder does not require dmem_req to remain asserted while dmem_gnt=0.
  - Inputs are sampled only in accept cycles; dmem_wdata and dmem_strb are ignored on reads.
- dmem_ack while dmem_recv=0 is ignored.

Optional Feature:
- Macro: FRV_DMEM_RSP_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - dmem_gnt is additionally forced to 0 whenever LFSR[1:0]==2'b00.
  - Queue head presentation is delayed: dmem_recv is forced to 0 when LFSR[3:2]==2'b00.
  - Head data is not popped while masked.
  - This exercises LSU hold, busy and backpressure paths.
- When undefined: no LFSR is instantiated; grant and response follow the base rules exactly.

Test Plan:
- Reset then write word: req, wen=1, addr=BASE+0x10, strb=1111, wdata=32'hDEADBEEF -> gnt=1 that cycle. Next cycle recv=1, error=0, rdata=0; ack pops it.
- Byte strobes: write 32'h11223344 strb=1111 to 0x20, then write 32'hAABBCCDD strb=0101 to 0x20, then read 0x20 -> rdata=32'h11BB33DD. Back-to-back read after write in consecutive accepts sees the new data.
- Out of range (DEPTH_WORDS=1024, BASE=0): read addr=0x1000 -> error=1, rdata=0. Write to 0x1000 leaves RAM unchanged (verify via read of 0x0).
- Backpressure (OUTSTANDING=2): hold ack=0 and issue 3 reads -> 2 accepted, gnt=0 while count=2, recv held with stable head data. Assert ack one cycle -> gnt returns the following cycle and responses arrive in issue order.
- Simultaneous accept and pop with a steady stream (req=1, ack=1 every cycle) -> one accept per cycle, count stays 1, responses in order, 1-cycle latency.
- Reset mid-traffic: 2 responses pending, g_reset=1 for one cycle -> recv=0 and gnt=0 during reset and the cycle after. No stale response afterwards; RAM data written before reset is still readable.
